// File: rtl/linear_seq_pkg.sv
// Shared types and width helpers for the linear-layer sequencer.
//   seq_state_t : sequencer FSM state encoding
//   seq_tag_t   : in-flight chunk tag {last, idx} carried through the tag pipe
//   cnt_w/idx_w : width helpers for counters (0..max) and indices (0..n-1)
package linear_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Width needed to hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width needed to index n_val entries (at least one bit).
    function automatic int idx_w(input int n_val);
        return (n_val > 1) ? $clog2(n_val) : 1;
    endfunction

    localparam int SEQ_MAX_OUTPUTS = 256;
    localparam int SEQ_IDX_W       = idx_w(SEQ_MAX_OUTPUTS);

    typedef struct packed {
        logic                 last;
        logic [SEQ_IDX_W-1:0] idx;
    } seq_tag_t;

endpackage

// File: rtl/linear_layer_sequencer_tag_pipe.sv
// seq_tag_pipe: enable-gated shift register of seq_tag_t tracking chunks
// through the fixed datapath latency.
//   clk, rst (sync, active-low), clr (sync clear), en (shift when high)
//   tag_in  : tag entering stage 0
//   tag_out : tag at the final stage
//   pending : a neuron-completing tag is still in a non-final stage
module seq_tag_pipe
    import linear_seq_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     en,
    input  seq_tag_t tag_in,
    output seq_tag_t tag_out,
    output logic     pending
);

    seq_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

    // The final stage is excluded: once the last completing tag sits there,
    // its out_valid is already being presented and draining can stop.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage_q[i].last;
        end
    end

endmodule

// File: rtl/linear_layer_sequencer.sv
// linear_layer_sequencer: steps weight/feature memories chunk by chunk over a
// whole linear layer, gates the datapath clock-enable and flags finished
// output neurons after the fixed pipeline latency.
// Ports: clk, rst (sync, active-low), start/cfg_chunks/cfg_outputs (layer
// request), stall (freezes everything), ce/issue/w_addr/f_addr/first_chunk/
// last_chunk (datapath drive), out_valid/out_idx (finished neuron),
// busy/done (layer handshake).
// Optional: define LINEAR_SEQ_PERF_EN to add saturating 32-bit
// perf_busy_cycles / perf_stall_cycles outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; config latched on an accepted start
// ST_RUN   | one chunk issued per unstalled cycle, back-to-back
// ST_DRAIN | no issues; ce keeps the pipe moving until the last tag lands
// ST_DONE  | done pulse, then back to idle
module linear_layer_sequencer
    import linear_seq_pkg::*;
#(
    parameter  int N           = 16,
    parameter  int MAX_CHUNKS  = 64,
    parameter  int MAX_OUTPUTS = SEQ_MAX_OUTPUTS,
    parameter  int PIPE_LAT    = 6,
    localparam int CW  = cnt_w(MAX_CHUNKS),
    localparam int OW  = cnt_w(MAX_OUTPUTS),
    localparam int WAW = idx_w(MAX_CHUNKS * MAX_OUTPUTS),
    localparam int FAW = idx_w(MAX_CHUNKS),
    localparam int IW  = idx_w(MAX_OUTPUTS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CW-1:0]  cfg_chunks,
    input  logic [OW-1:0]  cfg_outputs,
    input  logic           stall,
    output logic           ce,
    output logic           issue,
    output logic [WAW-1:0] w_addr,
    output logic [FAW-1:0] f_addr,
    output logic           first_chunk,
    output logic           last_chunk,
    output logic           out_valid,
    output logic [IW-1:0]  out_idx,
    output logic           busy,
`ifdef LINEAR_SEQ_PERF_EN
    output logic [31:0]    perf_busy_cycles,
    output logic [31:0]    perf_stall_cycles,
`endif
    output logic           done
);

    seq_state_t     state_q, state_d;
    logic [CW-1:0]  chunks_q, c_q;
    logic [OW-1:0]  outs_q, o_q;
    logic [WAW-1:0] w_addr_q;
    logic           first_q, last_q;
    logic           accept, cfg_zero, o_final, pipe_pending;
    seq_tag_t       tag_in, tag_out;

    assign accept   = (state_q == ST_IDLE) && start && !stall;
    assign cfg_zero = (cfg_chunks == '0) || (cfg_outputs == '0);
    assign o_final  = (o_q == outs_q - OW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (!stall) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = cfg_zero ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_q && o_final) state_d = ST_DRAIN;
            ST_DRAIN: if (!pipe_pending) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        issue = (state_q == ST_RUN) && !stall;
        ce    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !stall;
    end

    // Chunk/neuron counters. w_addr walks linearly, which equals o*cfg_chunks+c
    // without a multiplier. first/last are precomputed for the next issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chunks_q <= '0;
            outs_q   <= '0;
            c_q      <= '0;
            o_q      <= '0;
            w_addr_q <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                chunks_q <= cfg_chunks;
                outs_q   <= cfg_outputs;
                c_q      <= '0;
                o_q      <= '0;
                w_addr_q <= '0;
                first_q  <= !cfg_zero;
                last_q   <= !cfg_zero && (cfg_chunks == CW'(1));
            end else if (state_q == ST_RUN) begin
                if (last_q && o_final) begin
                    c_q      <= '0;
                    o_q      <= '0;
                    w_addr_q <= '0;
                    first_q  <= 1'b0;
                    last_q   <= 1'b0;
                end else if (last_q) begin
                    c_q      <= '0;
                    o_q      <= o_q + OW'(1);
                    w_addr_q <= w_addr_q + WAW'(1);
                    first_q  <= 1'b1;
                    last_q   <= (chunks_q == CW'(1));
                end else begin
                    c_q      <= c_q + CW'(1);
                    w_addr_q <= w_addr_q + WAW'(1);
                    first_q  <= 1'b0;
                    last_q   <= (c_q + CW'(2) == chunks_q);
                end
            end
        end
    end

    assign w_addr      = w_addr_q;
    assign first_chunk = first_q;
    assign last_chunk  = last_q;

    // The feature memory is chunk-addressed, so N never scales the index;
    // a degenerate zero-element chunk has nothing to fetch.
    generate
        if (N > 0) begin : g_f_addr
            assign f_addr = FAW'(c_q);
        end else begin : g_f_addr_none
            assign f_addr = '0;
        end
    endgenerate

    always_comb begin
        tag_in = '0;
        if (issue) begin
            tag_in.last = last_q;
            tag_in.idx  = SEQ_IDX_W'(o_q);
        end
    end

    seq_tag_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (ce),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .pending (pipe_pending)
    );

    // out_valid is held while stalled, like every other frozen output.
    assign out_valid = tag_out.last;
    assign out_idx   = IW'(tag_out.idx);

`ifdef LINEAR_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst || accept) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (busy && stall && !(&perf_stall_cycles)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_linear_layer_sequencer.sv
module tb_linear_layer_sequencer;

    localparam int MAX_CHUNKS  = 64;
    localparam int MAX_OUTPUTS = 256;
    localparam int PIPE_LAT    = 6;
    localparam int CW  = $clog2(MAX_CHUNKS + 1);
    localparam int OW  = $clog2(MAX_OUTPUTS + 1);
    localparam int WAW = $clog2(MAX_CHUNKS * MAX_OUTPUTS);
    localparam int FAW = $clog2(MAX_CHUNKS);
    localparam int IW  = $clog2(MAX_OUTPUTS);
    localparam int CYC_CAP = 4000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [CW-1:0]  cfg_chunks;
    logic [OW-1:0]  cfg_outputs;
    logic           stall;
    logic           ce, issue, first_chunk, last_chunk, out_valid, busy, done;
    logic [WAW-1:0] w_addr;
    logic [FAW-1:0] f_addr;
    logic [IW-1:0]  out_idx;
`ifdef LINEAR_SEQ_PERF_EN
    logic [31:0]    perf_busy_cycles, perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit stall_plan [0:CYC_CAP];

    always #5 clk = ~clk;

    linear_layer_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_chunks        (cfg_chunks),
        .cfg_outputs       (cfg_outputs),
        .stall             (stall),
        .ce                (ce),
        .issue             (issue),
        .w_addr            (w_addr),
        .f_addr            (f_addr),
        .first_chunk       (first_chunk),
        .last_chunk        (last_chunk),
        .out_valid         (out_valid),
        .out_idx           (out_idx),
        .busy              (busy),
`ifdef LINEAR_SEQ_PERF_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .done              (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue"}, 32'(issue), 0);
        chk({tag, "_ce"}, 32'(ce), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_w_addr"}, 32'(w_addr), 0);
        chk({tag, "_f_addr"}, 32'(f_addr), 0);
        chk({tag, "_first"}, 32'(first_chunk), 0);
        chk({tag, "_last"}, 32'(last_chunk), 0);
        chk({tag, "_out_idx"}, 32'(out_idx), 0);
    endtask

    // Reference model: q counts unstalled cycles since start. Issue k happens
    // at q==k; neuron n's last chunk is issue (n+1)*C-1 and becomes visible
    // PIPE_LAT unstalled steps later; done follows the final one.
    // mode: 0 no stall, 1 stall in cycles 5..7, 2 random stall.
    task automatic run_layer(input int cc, input int oc, input int restart_cyc, input int mode,
                             output int done_at, output int busy_cnt, output int stall_cnt);
        int  n, q, t, end_q, k;
        bit  zero, busy_e, run_e, ov_e, ce_e;
        n     = cc * oc;
        zero  = (n == 0);
        end_q = zero ? 0 : n + PIPE_LAT;
        for (int i = 0; i <= CYC_CAP; i++) begin
            if (mode == 1)      stall_plan[i] = (i >= 5 && i <= 7);
            else if (mode == 2) stall_plan[i] = ($urandom_range(0, 99) < 25);
            else                stall_plan[i] = 1'b0;
        end
        stall_plan[0] = 1'b0;
        done_at   = -1;
        busy_cnt  = 0;
        stall_cnt = 0;

        @(posedge clk); #1;
        start       = 1'b1;
        stall       = 1'b0;
        cfg_chunks  = CW'(cc);
        cfg_outputs = OW'(oc);
        @(negedge clk);
        chk("busy_cycle0", 32'(busy), 0);

        q = 0;
        t = 1;
        while (t < CYC_CAP) begin
            @(posedge clk); #1;
            start = (t == restart_cyc);
            if (t == restart_cyc) cfg_chunks = CW'((cc == 2) ? 3 : 2);
            stall = stall_plan[t];
            @(negedge clk);
            busy_e = (q <= end_q);
            run_e  = !zero && (q < n);
            ce_e   = !stall && !zero && (q < n + PIPE_LAT);
            k      = q - PIPE_LAT + 1;
            ov_e   = !zero && (q >= PIPE_LAT) && (k % cc == 0) && (k / cc <= oc);
            chk("busy", 32'(busy), 32'(busy_e));
            chk("done", 32'(done), 32'(q == end_q));
            chk("issue", 32'(issue), 32'(run_e && !stall));
            chk("ce", 32'(ce), 32'(ce_e));
            chk("out_valid", 32'(out_valid), 32'(ov_e));
            if (run_e) begin
                chk("w_addr", 32'(w_addr), 32'(q));
                chk("f_addr", 32'(f_addr), 32'(q % cc));
                chk("first_chunk", 32'(first_chunk), 32'(q % cc == 0));
                chk("last_chunk", 32'(last_chunk), 32'(q % cc == cc - 1));
            end
            if (ov_e) chk("out_idx", 32'(out_idx), 32'(k / cc - 1));
            if (done === 1'b1 && done_at < 0) done_at = t;
            if (busy_e) begin
                busy_cnt++;
                if (stall) stall_cnt++;
            end
            if (!busy_e) break;
            if (!stall) q++;
            t++;
        end
        if (t >= CYC_CAP) begin
            n_checks++;
            $error("FAIL timeout layer did not finish within %0d cycles", CYC_CAP);
        end
        start = 1'b0;
        stall = 1'b0;
`ifdef LINEAR_SEQ_PERF_EN
        chk("perf_busy", perf_busy_cycles, 32'(busy_cnt));
        chk("perf_stall", perf_stall_cycles, 32'(stall_cnt));
`endif
    endtask

    initial begin
        int done_at, busy_cnt, stall_cnt, rc, ro;
        rst         = 1'b0;
        start       = 1'b0;
        stall       = 1'b0;
        cfg_chunks  = '0;
        cfg_outputs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Baseline layer: 4 chunks x 3 neurons, done in cycle 19.
        run_layer(4, 3, -1, 0, done_at, busy_cnt, stall_cnt);
        chk("base_done_cycle", 32'(done_at), 19);

        // Stall in cycles 5..7 shifts everything by 3.
        run_layer(4, 3, -1, 1, done_at, busy_cnt, stall_cnt);
        chk("stall_done_cycle", 32'(done_at), 22);
`ifdef LINEAR_SEQ_PERF_EN
        chk("stall_perf_busy_22", perf_busy_cycles, 22);
        chk("stall_perf_stall_3", perf_stall_cycles, 3);
`endif

        // Single-chunk neurons: first and last on every issue.
        run_layer(1, 2, -1, 0, done_at, busy_cnt, stall_cnt);
        chk("c1_done_cycle", 32'(done_at), 9);

        // Zero config: no issues, done in cycle 1.
        run_layer(4, 0, -1, 0, done_at, busy_cnt, stall_cnt);
        chk("o0_done_cycle", 32'(done_at), 1);
        run_layer(0, 3, -1, 0, done_at, busy_cnt, stall_cnt);
        chk("c0_done_cycle", 32'(done_at), 1);

        // Start re-pulsed mid-run (with altered config) must be ignored.
        run_layer(4, 3, 5, 0, done_at, busy_cnt, stall_cnt);
        chk("restart_done_cycle", 32'(done_at), 19);

        // Full-width chunk count.
        run_layer(MAX_CHUNKS, 2, -1, 0, done_at, busy_cnt, stall_cnt);

        // Randomized layers with random stall.
        for (int r = 0; r < 6; r++) begin
            rc = int'($urandom_range(1, 6));
            ro = int'($urandom_range(1, 4));
            run_layer(rc, ro, -1, 2, done_at, busy_cnt, stall_cnt);
        end

        // Reset pulse in cycle 6 abandons the layer without done.
        @(posedge clk); #1;
        start       = 1'b1;
        cfg_chunks  = CW'(4);
        cfg_outputs = OW'(3);
        for (int t = 1; t <= 6; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (t == 5) begin
                @(negedge clk);
                chk("pre_reset_issue", 32'(issue), 1);
            end
            if (t == 6) rst = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        for (int t = 8; t < 30; t++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_reset_busy", 32'(busy), 0);
            chk("post_reset_done", 32'(done), 0);
            chk("post_reset_out_valid", 32'(out_valid), 0);
        end

        // The sequencer still works after the abandoned layer.
        run_layer(2, 2, -1, 0, done_at, busy_cnt, stall_cnt);
        chk("after_reset_done_cycle", 32'(done_at), 1 + 4 + PIPE_LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
